// File: rtl/serial_subtractor_16_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BorrowIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             BorrowOut;
  logic             Overflow;
  logic             Zero;

  modport master (
    output start, A, B, BorrowIn,
    input  busy, done, Diff, BorrowOut, Overflow, Zero
  );

  modport slave (
    input  start, A, B, BorrowIn,
    output busy, done, Diff, BorrowOut, Overflow, Zero
  );
endinterface

// File: rtl/serial_subtractor_16.sv
// Bit-serial Diff = A - B - BorrowIn, LSB first, one full-subtractor cell per clock.
// Results are registered at completion and held until the next completion.
module serial_subtractor_16 #(
  parameter int unsigned WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_16_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             br;
  logic             br_next;
  logic             d;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             ovf_reg;
  logic             zero_reg;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    d        = a_reg[0] ^ b_reg[0] ^ br;
    br_next  = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br);
    res_next = {d, res_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      cnt      <= '0;
      diff_reg <= '0;
      bout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= bus.A;
      b_reg   <= bus.B;
      br      <= bus.BorrowIn;
      a_msb   <= bus.A[WIDTH-1];
      b_msb   <= bus.B[WIDTH-1];
      res_reg <= '0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      res_reg <= res_next;
      br      <= br_next;
      cnt     <= cnt + 1'b1;
      if (last_bit) begin
        diff_reg <= res_next;
        bout_reg <= br_next;
        ovf_reg  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
        zero_reg <= (res_next == '0);
      end
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.done      = (state == DONE);
  assign bus.Diff      = diff_reg;
  assign bus.BorrowOut = bout_reg;
  assign bus.Overflow  = ovf_reg;
  assign bus.Zero      = zero_reg;
endmodule

// File: tb/tb_serial_subtractor_16.sv
// Directed and random checks of the bit-serial subtractor against hand values and a reference model.
module tb_serial_subtractor_16;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_subtractor_16_if #(.WIDTH(16)) bus ();

  serial_subtractor_16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one start cycle and returns at the first negedge after accept.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
    bus.start    = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.BorrowIn = bin;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Counts negedges since accept until done is seen (bounded).
  task automatic wait_done(input int from, output int cyc, output int busy_cnt);
    cyc      = from;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] ed, input logic eb,
                              input logic eo, input logic ez);
    check({tag, ".diff"}, 32'(bus.Diff), 32'(ed));
    check({tag, ".bout"}, 32'(bus.BorrowOut), 32'(eb));
    check({tag, ".ovf"},  32'(bus.Overflow), 32'(eo));
    check({tag, ".zero"}, 32'(bus.Zero), 32'(ez));
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
    int cyc, bc;
    start_op(a, b, bin);
    wait_done(1, cyc, bc);
    check({tag, ".lat"}, 32'(cyc), 32'd17);
    check({tag, ".busycyc"}, 32'(bc), 32'd16);
    check({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    check_result(tag, ed, eb, eo, ez);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int cyc, bc, pulses;
    logic [15:0] ra, rb;
    logic        rbin;
    logic [16:0] rref;
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.BorrowIn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("op5m3",     16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    do_op("op0m1",     16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    do_op("op10m1b",   16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0);
    do_op("op8000m1",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    do_op("op7fffmff", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

    // Start pulse during busy cycle 5 must be ignored
    start_op(16'h1234, 16'h1234, 1'b0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6, cyc, bc);
    check("ign.lat", 32'(cyc), 32'd17);
    check_result("ign", 16'h0000, 1'b0, 1'b0, 1'b1);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("ign.extra_done", 32'(pulses), 32'd0);
    check("ign.idle_busy", 32'(bus.busy), 32'd0);

    // Back-to-back: second start presented during the DONE cycle
    start_op(16'h0020, 16'h0001, 1'b0);
    wait_done(1, cyc, bc);
    check("b2b1.lat", 32'(cyc), 32'd17);
    check_result("b2b1", 16'h001F, 1'b0, 1'b0, 1'b0);
    start_op(16'h00FF, 16'h000F, 1'b0);
    check("b2b2.busy", 32'(bus.busy), 32'd1);
    check("b2b2.done", 32'(bus.done), 32'd0);
    check("b2b2.hold", 32'(bus.Diff), 32'h001F);
    repeat (8) @(negedge clk);
    check("b2b2.hold_mid", 32'(bus.Diff), 32'h001F);
    wait_done(9, cyc, bc);
    check("b2b2.lat", 32'(cyc), 32'd17);
    check_result("b2b2", 16'h00F0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset in busy cycle 8
    start_op(16'h4444, 16'h1111, 1'b0);
    repeat (7) @(negedge clk);
    check("rstmid.pre", 32'(bus.Diff), 32'h00F0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.busy", 32'(bus.busy), 32'd0);
    check("rstmid.done", 32'(bus.done), 32'd0);
    check_result("rstmid", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    check("rstmid.no_done", 32'(pulses), 32'd0);
    do_op("post_rst", 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      rref = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      do_op("rand", ra, rb, rbin, rref[15:0], rref[16],
            (ra[15] != rb[15]) && (rref[15] != ra[15]), rref[15:0] == 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor_16.md
Name: serial_subtractor_16

Overview:
- Bit-serial WIDTH-bit subtractor computing Diff = A - B - BorrowIn, one bit per clock, LSB first, through a single full-subtractor cell.
- Complements the combinational 16-bit ripple adder in the arithmetic library: same operand width, opposite operation.
- Trades latency for area.
- Used by the sprite datapath for coordinate deltas, via a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising edge when not busy
- A  input  WIDTH  minuend; captured on accepted start
- B  input  WIDTH  subtrahend; captured on accepted start
- BorrowIn  input  1  initial borrow; captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  single-cycle pulse: result valid
- Diff  output  WIDTH  registered difference
- BorrowOut  output  1  final borrow (1 when A < B + BorrowIn, unsigned)
- Overflow  output  1  two's-complement signed overflow
- Zero  output  1  Diff == 0

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE.
  - busy = 0, done = 0, Diff = 0, BorrowOut = 0, Overflow = 0, Zero = 0.
  - Internal shift registers, borrow flop and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start = 1: capture A, B and BorrowIn into internal regs.
  - Set counter = 0 and go to SHIFT. busy rises in the following cycle.
- SHIFT, on each edge:
  - a = a_reg[0], b = b_reg[0], br = borrow flop.
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - Shift a_reg and b_reg right by 1; shift d into the MSB of the result shift register; borrow flop <= br_next; counter + 1.
  - On the edge where counter == WIDTH-1 (the WIDTH-th bit edge):
    - Diff <= final shifted result; BorrowOut <= br_next.
    - Overflow <= (A_cap[MSB] != B_cap[MSB]) && (result[MSB] != A_cap[MSB]), using the captured operands.
    - Zero <= (result == 0).
    - Go to DONE.
- DONE:
  - done = 1, busy = 0 for exactly one cycle, then IDLE.
  - A start seen in DONE is accepted exactly as in IDLE, giving back-to-back operation.
- Latency: start accepted at edge 0, bits processed at edges 1..WIDTH, done high during the cycle after edge WIDTH. That is WIDTH+1 cycles from accept to done; throughput is one op per WIDTH+1 cycles.
- start while busy (SHIFT): ignored, with no effect on operands or the count.
- Diff, BorrowOut, Overflow and Zero are updated only at completion. They hold the previous result throughout busy and until the next completion.
- Operand inputs may change freely after the accept edge.
- Reset mid-operation: the operation is aborted, all outputs return to reset values, and no done pulse is produced.
- Arithmetic is modulo 2^WIDTH.
- busy and done are never high in the same cycle.

Test Plan:
- Reset then A=0x0005, B=0x0003, BorrowIn=0, start 1 cycle -> busy for 16 cycles, done pulse 17 cycles after accept; Diff=0x0002, BorrowOut=0, Overflow=0, Zero=0.
- A=0x0000, B=0x0001, BorrowIn=0 -> Diff=0xFFFF, BorrowOut=1, Overflow=0. Then A=0x0010, B=0x0001, BorrowIn=1 -> Diff=0x000E, BorrowOut=0.
- A=0x8000, B=0x0001 -> Diff=0x7FFF, Overflow=1, BorrowOut=0. Then A=0x7FFF, B=0xFFFF -> Diff=0x8000, Overflow=1, BorrowOut=1.
- A=0x1234, B=0x1234 -> Diff=0x0000, Zero=1, BorrowOut=0. Pulse start again at cycle 5 of busy with A=0xFFFF -> ignored; result is still 0x0000 and there is exactly one done pulse.
- Back-to-back: start held high through DONE with A=0x00FF, B=0x000F -> second op accepted in the DONE cycle; Diff=0x00F0 17 cycles later. Outputs hold the first result until then.
- Start an op, drive rst_n low at cycle 8 of busy -> all outputs 0 immediately (async). No done pulse; the next op after reset computes correctly.
- Random compare: 1000 random A, B, BorrowIn against a reference model ({BorrowOut, Diff} = A - B - BorrowIn) -> zero mismatches.
